// File: rtl/bitop_pipe.sv
// Two-stage pipelined bitwise/unary operator (NOT, NEG, REV, PASS, XOR, ANDN, POPC)
// with valid/ready handshakes; results and flags are registered in stage 2.
module bitop_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_zero,
    output logic             out_ovf
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_NEG  = 3'b001,
        OP_REV  = 3'b010,
        OP_PASS = 3'b011,
        OP_XOR  = 3'b100,
        OP_ANDN = 3'b101,
        OP_POPC = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_s1_valid;
    op_e              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [TAGW-1:0]  r_s1_tag;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic [TAGW-1:0]  r_s2_tag;
    logic             r_s2_zero;
    logic             r_s2_ovf;

    logic             w_advance;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_zero;

    assign w_advance = !r_s2_valid || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_s1_op)
            OP_NEG: begin
                w_res = ~r_s1_a + WIDTH'(1);
                w_ovf = (r_s1_a == MOST_NEG);
            end
            OP_REV: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_res[i] = r_s1_a[WIDTH-1-i];
                end
            end
            OP_PASS: w_res = r_s1_a;
            OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            OP_ANDN: w_res = r_s1_a & ~r_s1_b;
            OP_POPC: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_res = w_res + WIDTH'(r_s1_a[i]);
                end
            end
            default: w_res = ~r_s1_a;  // NOT and the reserved encoding
        endcase
        w_zero = (w_res == '0);
    end

    // Payload registers load only with valid content, so bubbles leave outputs untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_NOT;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_ovf   <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_res;
                r_s2_tag  <= r_s1_tag;
                r_s2_zero <= w_zero;
                r_s2_ovf  <= w_ovf;
            end
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op  <= op_e'(in_op);
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_tag <= in_tag;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;
    assign out_zero  = r_s2_zero;
    assign out_ovf   = r_s2_ovf;

endmodule

// File: tb/tb_bitop_pipe.sv
// Directed bench for bitop_pipe: 32-bit instance for the main scenarios,
// 8-bit instance for the width sweep.
module tb_bitop_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_zero;
    logic        out_ovf;

    bitop_pipe #(.WIDTH(32), .TAGW(5)) u_dut (
        .clock(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero), .out_ovf(out_ovf)
    );

    logic       v8_in_valid = 1'b0;
    logic       v8_in_ready;
    logic [2:0] v8_in_op = 3'd0;
    logic [7:0] v8_in_a = '0;
    logic [7:0] v8_in_b = '0;
    logic [4:0] v8_in_tag = '0;
    logic       v8_out_valid;
    logic       v8_out_ready = 1'b1;
    logic [7:0] v8_out_data;
    logic [4:0] v8_out_tag;
    logic       v8_out_zero;
    logic       v8_out_ovf;

    bitop_pipe #(.WIDTH(8), .TAGW(5)) u_dut8 (
        .clock(clk), .reset(rst),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_op(v8_in_op),
        .in_a(v8_in_a), .in_b(v8_in_b), .in_tag(v8_in_tag),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_data(v8_out_data),
        .out_tag(v8_out_tag), .out_zero(v8_out_zero), .out_ovf(v8_out_ovf)
    );

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++;
        if (out_data !== 32'h0 || out_tag !== 5'd0 || out_zero !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h tag=%0d zero=%b ovf=%b exp all 0",
                     out_data, out_tag, out_zero, out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_not;
        out_ready = 1'b1;
        drive(3'b000, 32'h0000FFFF, 32'h0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL not_early_valid got %b exp 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF0000 || out_tag !== 5'd3 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL not_result got v=%b data=%h tag=%0d zero=%b exp v=1 data=ffff0000 tag=3 zero=0",
                     out_valid, out_data, out_tag, out_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_neg_boundary;
        drive(3'b001, 32'h80000000, 32'h0, 5'd7);
        @(negedge clk);
        drive(3'b001, 32'h00000000, 32'h0, 5'd8);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h80000000 || out_ovf !== 1'b1 || out_zero !== 1'b0 || out_tag !== 5'd7) begin
            errors++;
            $display("FAIL neg_min got v=%b data=%h ovf=%b zero=%b tag=%0d exp v=1 data=80000000 ovf=1 zero=0 tag=7",
                     out_valid, out_data, out_ovf, out_zero, out_tag);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_ovf !== 1'b0 || out_zero !== 1'b1 || out_tag !== 5'd8) begin
            errors++;
            $display("FAIL neg_zero got v=%b data=%h ovf=%b zero=%b tag=%0d exp v=1 data=0 ovf=0 zero=1 tag=8",
                     out_valid, out_data, out_ovf, out_zero, out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exp [4];
        ops[0] = 3'b010; as[0] = 32'h00000001; bs[0] = 32'h0;        exp[0] = 32'h80000000;
        ops[1] = 3'b110; as[1] = 32'hF0F0F0F0; bs[1] = 32'h0;        exp[1] = 32'd16;
        ops[2] = 3'b100; as[2] = 32'hAAAAAAAA; bs[2] = 32'hFFFFFFFF; exp[2] = 32'h55555555;
        ops[3] = 3'b101; as[3] = 32'h000000FF; bs[3] = 32'h0000000F; exp[3] = 32'h000000F0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp[k-2] || out_tag !== 5'(10 + k - 2)) begin
                    errors++;
                    $display("FAIL b2b_%0d got v=%b data=%h tag=%0d exp v=1 data=%h tag=%0d",
                             k - 2, out_valid, out_data, out_tag, exp[k-2], 10 + k - 2);
                end
            end
            if (k < 4) drive(ops[k], as[k], bs[k], 5'(10 + k));
            else in_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%b exp 0", out_valid); end
    endtask

    task automatic test_backpressure;
        int          idx = 0;
        int          got = 0;
        logic        stalled = 1'b0;
        logic [31:0] held_data = '0;
        logic [4:0]  held_tag = '0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c <= 8);
            if (idx < 4) drive(3'b011, 32'h11 * (idx + 1), 32'h0, 5'(idx + 1));
            else in_valid = 1'b0;
            #1;
            if (stalled) begin
                checks++;
                if (out_data !== held_data || out_tag !== held_tag) begin
                    errors++;
                    $display("FAIL bp_stable got data=%h tag=%0d exp data=%h tag=%0d",
                             out_data, out_tag, held_data, held_tag);
                end
            end
            if (c >= 4 && c <= 8) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got %b exp 0", c, in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 4 || out_tag !== 5'(got + 1) || out_data !== 32'h11 * (got + 1)) begin
                    errors++;
                    $display("FAIL bp_order got tag=%0d data=%h exp tag=%0d data=%h",
                             out_tag, out_data, got + 1, 32'h11 * (got + 1));
                end
                got++;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_tag  = out_tag;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        drive(3'b011, 32'h1234, 32'h0, 5'd20);
        @(negedge clk);
        drive(3'b011, 32'h5678, 32'h0, 5'd21);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_leak k=%0d got tag=%0d exp no result", k, out_tag); end
        end
    endtask

    task automatic test_width8;
        logic [2:0] ops [3];
        logic [7:0] as  [3];
        logic [7:0] exp [3];
        ops[0] = 3'b000; as[0] = 8'h5A; exp[0] = 8'hA5;
        ops[1] = 3'b001; as[1] = 8'h01; exp[1] = 8'hFF;
        ops[2] = 3'b110; as[2] = 8'hFF; exp[2] = 8'h08;
        checks++;
        if (v8_in_ready !== 1'b1) begin errors++; $display("FAIL w8_in_ready got %b exp 1", v8_in_ready); end
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) begin
                checks++;
                if (v8_out_valid !== 1'b1 || v8_out_data !== exp[k-2] || v8_out_ovf !== 1'b0 || v8_out_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL w8_%0d got v=%b data=%h ovf=%b zero=%b exp v=1 data=%h ovf=0 zero=0",
                             k - 2, v8_out_valid, v8_out_data, v8_out_ovf, v8_out_zero, exp[k-2]);
                end
            end
            if (k < 3) begin
                v8_in_valid = 1'b1;
                v8_in_op    = ops[k];
                v8_in_a     = as[k];
                v8_in_tag   = 5'(k);
            end else begin
                v8_in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_not;
        test_neg_boundary;
        test_back_to_back;
        test_backpressure;
        test_reset_midflight;
        test_width8;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
